// File: rtl/key_sched_ctrl.sv
// AES key-expansion sequencer: walks word index i through the cipher-key load
// and expansion phases and drives the mux select and transform enables per word.
module key_sched_ctrl (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Start,
    input  logic [1:0] KeyLen,
    input  logic       Stall,
    output logic [2:0] Sel,
    output logic [5:0] WordIdx,
    output logic       WordValid,
    output logic       LoadKey,
    output logic       RotSubEn,
    output logic       SubOnlyEn,
    output logic [3:0] RconIdx,
    output logic       Busy,
    output logic       Done,
    output logic       Error,
    output logic [1:0] DbgState
);

    // Handshake: a word is transferred in every cycle where WordValid=1.
    // Stall=1 from downstream freezes all sequencing state and masks WordValid
    // combinationally, so the held word is offered again when Stall falls.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic [2:0] mod_q, mod_d;
    logic [3:0] rcon_q, rcon_d;
    logic [3:0] nk_q, nk_d;
    logic [5:0] ntot_q, ntot_d;
    logic       busy_q, load_q, rot_q, sub_q, done_q, err_q;
    logic       busy_d, load_d, rot_d, sub_d, done_d, err_d;
    logic       mod_last, key_last, sched_last;
    logic [2:0] mod_inc;

    always_comb begin
        mod_last   = ({1'b0, mod_q} == (nk_q - 4'd1));
        mod_inc    = mod_last ? 3'd0 : (mod_q + 3'd1);
        key_last   = (idx_q == ({2'b00, nk_q} - 6'd1));
        sched_last = (idx_q == (ntot_q - 6'd1));

        state_d = state_q;
        idx_d   = idx_q;
        mod_d   = mod_q;
        rcon_d  = rcon_q;
        nk_d    = nk_q;
        ntot_d  = ntot_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (KeyLen == 2'b11) begin
                        err_d = 1'b1;
                    end else begin
                        // Ntot = 4 * (Nk + 7): 44, 52 or 60 words
                        case (KeyLen)
                            2'b00:   begin nk_d = 4'd4; ntot_d = 6'd44; end
                            2'b01:   begin nk_d = 4'd6; ntot_d = 6'd52; end
                            default: begin nk_d = 4'd8; ntot_d = 6'd60; end
                        endcase
                        idx_d   = 6'd0;
                        mod_d   = 3'd0;
                        rcon_d  = 4'd1;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (!Stall) begin
                    idx_d = idx_q + 6'd1;
                    mod_d = mod_inc;
                    if (key_last) begin
                        state_d = EXPAND;
                    end
                end
            end
            EXPAND: begin
                if (!Stall) begin
                    if (mod_q == 3'd0) begin
                        rcon_d = rcon_q + 4'd1;
                    end
                    if (sched_last) begin
                        state_d = FINISH;
                    end else begin
                        idx_d = idx_q + 6'd1;
                        mod_d = mod_inc;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Output flags are derived from the next state so they land in flops.
        busy_d = (state_d == LOAD) || (state_d == EXPAND);
        load_d = (state_d == LOAD);
        rot_d  = (state_d == EXPAND) && (mod_d == 3'd0);
        sub_d  = (state_d == EXPAND) && (nk_d == 4'd8) && (mod_d == 3'd4);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            idx_q   <= 6'd0;
            mod_q   <= 3'd0;
            rcon_q  <= 4'd0;
            nk_q    <= 4'd4;
            ntot_q  <= 6'd44;
            busy_q  <= 1'b0;
            load_q  <= 1'b0;
            rot_q   <= 1'b0;
            sub_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mod_q   <= mod_d;
            rcon_q  <= rcon_d;
            nk_q    <= nk_d;
            ntot_q  <= ntot_d;
            busy_q  <= busy_d;
            load_q  <= load_d;
            rot_q   <= rot_d;
            sub_q   <= sub_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign Sel       = mod_q;
    assign WordIdx   = idx_q;
    assign RconIdx   = rcon_q;
    assign WordValid = busy_q & ~Stall;
    assign LoadKey   = load_q;
    assign RotSubEn  = rot_q;
    assign SubOnlyEn = sub_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Error     = err_q;
    assign DbgState  = state_q;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Directed bench for key_sched_ctrl: a model of each schedule fills an expected
// queue that a negedge monitor drains as words and Done pulses appear.
module tb_key_sched_ctrl;

    localparam int W = 18;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Start = 1'b0;
    logic [1:0] KeyLen = 2'b00;
    logic       Stall = 1'b0;
    logic [2:0] Sel;
    logic [5:0] WordIdx;
    logic       WordValid, LoadKey, RotSubEn, SubOnlyEn;
    logic [3:0] RconIdx;
    logic       Busy, Done, Error;
    logic [1:0] DbgState;

    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_fail = 0;
    int valid_total = 0;
    bit prev_valid = 1'b0;
    int base;

    key_sched_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .KeyLen(KeyLen), .Stall(Stall),
        .Sel(Sel), .WordIdx(WordIdx), .WordValid(WordValid), .LoadKey(LoadKey),
        .RotSubEn(RotSubEn), .SubOnlyEn(SubOnlyEn), .RconIdx(RconIdx), .Busy(Busy),
        .Done(Done), .Error(Error), .DbgState(DbgState)
    );

    // clock
    always #5 Clk = ~Clk;

    function automatic logic [W-1:0] pack(input bit v, input bit d, input int idx,
                                          input int sel, input bit ld, input bit rot,
                                          input bit sub, input int rcon);
        return {v, d, 6'(idx), 3'(sel), ld, rot, sub, 4'(rcon)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference schedule for one key length
    task automatic push_sched(input int kl);
        int nk, ntot;
        bit rot, sub;
        nk   = (kl == 0) ? 4 : (kl == 1) ? 6 : 8;
        ntot = 4 * (nk + 7);
        for (int i = 0; i < ntot; i++) begin
            rot = (i >= nk) && (i % nk == 0);
            sub = (nk == 8) && (i >= nk) && (i % 8 == 4);
            exp_q.push_back(pack(1'b1, 1'b0, i, i % nk, i < nk, rot, sub, rot ? i / nk : 0));
        end
        exp_q.push_back(pack(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0));
    endtask

    task automatic monitor();
        logic [W-1:0] obs, e;
        forever begin
            @(negedge Clk);
            if (WordValid || Done) begin
                if (WordValid)
                    obs = pack(1'b1, Done, int'(WordIdx), int'(Sel), LoadKey, RotSubEn,
                               SubOnlyEn, RotSubEn ? int'(RconIdx) : 0);
                else
                    obs = pack(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0);
                n_vec++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_out: observed 0x%0h expected none", obs);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("word", 32'(obs), 32'(e));
                end
                if (Done) chk("done_after_last", 32'(prev_valid), 32'd1);
            end
            if (WordValid) valid_total++;
            prev_valid = WordValid;
        end
    endtask

    task automatic start_sched(input int kl);
        base = valid_total;
        push_sched(kl);
        KeyLen = 2'(kl);
        Start  = 1'b1;
        @(posedge Clk); #1;
        Start  = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge Clk); #1;
            n++;
        end
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_idle"}, 32'({Busy, DbgState}), 32'd0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!Done && n < budget) begin
            @(posedge Clk); #1;
            n++;
        end
        chk({tag, "_done"}, 32'(Done), 32'd1);
    endtask

    task automatic wait_idx(input string tag, input int target, input int budget);
        int n = 0;
        while (!(Busy && WordIdx == 6'(target)) && n < budget) begin
            @(posedge Clk); #1;
            n++;
        end
        chk({tag, "_reached"}, 32'(Busy && WordIdx == 6'(target)), 32'd1);
    endtask

    initial begin
        fork
            monitor();
        join_none

        // reset
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_outs", 32'({Sel, WordIdx, RconIdx, WordValid, LoadKey, RotSubEn,
                               SubOnlyEn, Busy, Done, Error}), 32'd0);
        chk("reset_state", 32'(DbgState), 32'd0);
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        // AES-128, no stall
        start_sched(0);
        chk("a128_first", 32'({Busy, LoadKey, WordIdx, DbgState}), 32'({1'b1, 1'b1, 6'd0, 2'd1}));
        wait_done("a128", 200);
        chk("a128_count", 32'(valid_total - base), 32'd44);

        // AES-192 back-to-back, random stall
        @(posedge Clk); #1;
        start_sched(1);
        chk("b2b_busy", 32'(Busy), 32'd1);
        for (int n = 0; n < 500 && exp_q.size() != 0; n++) begin
            Stall = ($urandom_range(0, 3) == 0);
            @(posedge Clk); #1;
        end
        Stall = 1'b0;
        wait_idle("a192", 10);
        chk("a192_count", 32'(valid_total - base), 32'd52);

        // AES-256, Start with illegal KeyLen during EXPAND is ignored
        start_sched(2);
        wait_idx("a256_mid", 30, 100);
        KeyLen = 2'b11;
        Start  = 1'b1;
        @(posedge Clk); #1;
        Start  = 1'b0;
        chk("ign_start", 32'({DbgState, Error}), 32'({2'd2, 1'b0}));
        @(posedge Clk); #1;
        chk("ign_start_err", 32'(Error), 32'd0);
        wait_idle("a256", 200);
        chk("a256_count", 32'(valid_total - base), 32'd60);

        // illegal KeyLen from IDLE
        KeyLen = 2'b11;
        Start  = 1'b1;
        @(posedge Clk); #1;
        Start  = 1'b0;
        chk("err_pulse", 32'({Error, Busy, DbgState}), 32'({1'b1, 1'b0, 2'd0}));
        @(posedge Clk); #1;
        chk("err_clear", 32'({Error, Busy, DbgState}), 32'd0);

        // AES-128 with 3-cycle stall at i=17
        start_sched(0);
        wait_idx("stall17", 17, 100);
        Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk("stall_hold", 32'({WordValid, WordIdx, Sel, Busy}), 32'({1'b0, 6'd17, 3'd1, 1'b1}));
            @(posedge Clk); #1;
        end
        Stall = 1'b0;
        wait_idle("stall", 200);
        chk("stall_count", 32'(valid_total - base), 32'd44);

        // reset mid-EXPAND at i=25, then restart
        start_sched(0);
        wait_idx("abort25", 25, 100);
        Reset_n = 1'b0;
        #1;
        chk("abort_outs", 32'({Sel, WordIdx, RconIdx, WordValid, LoadKey, RotSubEn,
                               SubOnlyEn, Busy, Done, Error}), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        repeat (5) @(posedge Clk);
        #1;
        chk("abort_idle", 32'({DbgState, Done}), 32'd0);
        start_sched(0);
        chk("restart_idx0", 32'({WordValid, WordIdx}), 32'({1'b1, 6'd0}));
        wait_idle("restart", 200);
        chk("restart_count", 32'(valid_total - base), 32'd44);

        repeat (3) @(posedge Clk);
        #1;
        chk("final_queue", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/key_sched_ctrl.md
KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

Interface
REQ-001 SHALL have ports: Clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: Reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports: Start  in  1  begin schedule; sampled only in IDLE.
REQ-004 SHALL have ports: KeyLen  in  2  00=AES-128 (Nk=4), 01=AES-192 (Nk=6), 10=AES-256 (Nk=8), 11=illegal; sampled with Start.
REQ-005 SHALL have ports: Stall  in  1  downstream not ready; freezes sequencing.
REQ-006 SHALL have ports: Sel  out  3  select for the key-expansion 8:1 word mux.
REQ-007 SHALL have ports: WordIdx  out  6  index i of word produced this cycle.
REQ-008 SHALL have ports: WordValid  out  1  word i valid this cycle.
REQ-009 SHALL have ports: LoadKey  out  1  word i is a raw cipher-key word.
REQ-010 SHALL have ports: RotSubEn  out  1  apply RotWord+SubWord+Rcon to temp.
REQ-011 SHALL have ports: SubOnlyEn  out  1  apply SubWord only (AES-256, i mod 8 = 4).
REQ-012 SHALL have ports: RconIdx  out  4  Rcon round index, 1..10.
REQ-013 SHALL have ports: Busy  out  1  high in LOAD or EXPAND.
REQ-014 SHALL have ports: Done  out  1  one-cycle completion pulse.
REQ-015 SHALL have ports: Error  out  1  one-cycle pulse on Start with KeyLen=11.

Function
REQ-016 SHALL implement states IDLE, LOAD, EXPAND, FINISH.
REQ-017 SHALL in IDLE, on Start=1 with legal KeyLen, latch Nk and Ntot (44/52/60), clear WordIdx, mod counter and RconIdx, set RconIdx=1, go to LOAD next cycle.
REQ-018 SHALL on Start=1 with KeyLen=11 in IDLE pulse Error for one cycle and remain in IDLE.
REQ-019 SHALL ignore Start outside IDLE, including KeyLen changes.
REQ-020 SHALL in LOAD emit words i=0..Nk-1, one per non-stalled cycle, with WordValid=1, LoadKey=1, Sel=i[2:0], RotSubEn=SubOnlyEn=0.
REQ-021 SHALL move LOAD->EXPAND after word Nk-1 is emitted.
REQ-022 SHALL in EXPAND emit words i=Nk..Ntot-1, with WordValid=1, LoadKey=0, Sel=i mod Nk (via a wrapping mod counter, no divider).
REQ-023 SHALL assert RotSubEn iff i mod Nk = 0 in EXPAND; SubOnlyEn iff Nk=8 and i mod 8 = 4.
REQ-024 SHALL hold RconIdx constant across a group and increment it by 1 after each RotSubEn word is emitted; RconIdx valid only with RotSubEn.
REQ-025 SHALL move EXPAND->FINISH after word Ntot-1; FINISH pulses Done=1 for exactly one cycle (WordValid=0) then returns to IDLE.
REQ-026 SHALL, while Stall=1 in LOAD or EXPAND, hold state, WordIdx, Sel, RconIdx and all enables, and force WordValid=0; emission resumes the cycle Stall falls.
REQ-027 SHALL not let Stall delay the FINISH->IDLE transition or Done.
REQ-028 SHALL drive Busy=1 in LOAD and EXPAND only.
REQ-029 SHALL make all outputs registered or decoded solely from registered state (no Start/KeyLen combinational paths to outputs except Error).
REQ-030 SHALL accept Start in the cycle after FINISH (back-to-back schedules).

Reset
REQ-031 SHALL on Reset_n=0 asynchronously enter IDLE with Sel=0, WordIdx=0, RconIdx=0, WordValid=LoadKey=RotSubEn=SubOnlyEn=Busy=Done=Error=0.
REQ-032 SHALL, on reset mid-LOAD or mid-EXPAND, abort with no Done pulse; first Start after release restarts from i=0.

Verification
REQ-033 AES-128, Stall=0: Start -> 44 WordValid cycles, LoadKey on i=0..3, RotSubEn on i=4,8,...,40 with RconIdx 1..10, Done one cycle after i=43.
REQ-034 AES-256: RotSubEn on i=8,16,...,56 (RconIdx 1..7), SubOnlyEn on i=12,20,...,52, Sel=i mod 8, 60 words total.
REQ-035 AES-192: Sel sequence 0..5 repeating, RotSubEn at i=6,12,...,48 (RconIdx 1..8), 52 words.
REQ-036 Stall asserted 3 cycles at i=17 (AES-128): WordValid=0 for those cycles, WordIdx holds 17, next valid word is i=17, total valid count still 44.
REQ-037 KeyLen=11 with Start -> Error pulse 1 cycle, Busy stays 0; Start during EXPAND -> no effect on sequence.
REQ-038 Reset_n low at i=25 -> outputs zero immediately, no Done; new Start -> i restarts at 0.
